// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC default,
// FSM state encoding and the {pc,instr} bundle used by the prefetch FIFO.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master)
// and the instruction memory (slave).
interface fetch_if;

    logic        ftch_imem_req;
    logic [31:0] ftch_imem_addr;
    logic        imem_ftch_gnt;
    logic        imem_ftch_rvalid;
    logic [31:0] imem_ftch_rdata;

    modport master (
        output ftch_imem_req,
        output ftch_imem_addr,
        input  imem_ftch_gnt,
        input  imem_ftch_rvalid,
        input  imem_ftch_rdata
    );

    modport slave (
        input  ftch_imem_req,
        input  ftch_imem_addr,
        output imem_ftch_gnt,
        output imem_ftch_rvalid,
        output imem_ftch_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc,instr} entries; clear wins over push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rp;
    logic [AW-1:0]  wp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else if (clear) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, imem request credits, redirect flush,
// prefetch buffering and the fetch->decode pipeline register.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     imem,
    input  logic        dec_ftch_stall,
    input  logic        exec_ftch_redirect,
    input  logic [31:0] exec_ftch_target,
    output logic [31:0] ftch_dec_instr,
    output logic [31:0] ftch_dec_pc,
    output logic        ftch_dec_valid
);

    localparam int OW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] FD = FIFO_DEPTH;
    localparam logic [31:0] MO = MAX_OUTST;

    fetch_state_e  state;
    fetch_state_e  state_n;
    logic [31:0]   pc;
    logic [31:0]   tgt;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_n;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_n;
    logic [31:0]   opc [MAX_OUTST];
    logic [OW-1:0] orp;
    logic [OW-1:0] owp;
    logic          credit;
    logic          fire;
    logic          rsp;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  resp;
    logic [FW-1:0] fcount;
    logic          ffull;
    logic          fempty;

    function automatic logic [OW-1:0] nxt(input logic [OW-1:0] p);
        return (32'(p) == MO - 32'd1) ? '0 : p + OW'(1);
    endfunction

    assign tgt     = word_align(exec_ftch_target);
    assign credit  = (32'(outst) + 32'(fcount)) < FD && 32'(outst) < MO;
    assign fire    = imem.ftch_imem_req & imem.imem_ftch_gnt;
    assign rsp     = imem.imem_ftch_rvalid & (state == RUN)
                   & ~exec_ftch_redirect;
    assign resp    = '{pc: opc[orp], instr: imem.imem_ftch_rdata};
    assign pop     = ~exec_ftch_redirect & ~dec_ftch_stall & ~fempty;
    // A response only bypasses the FIFO when it is empty and decode is free.
    assign push    = rsp & (dec_ftch_stall | ~fempty);
    assign outst_n = outst + CW'(fire) - CW'(imem.imem_ftch_rvalid);

    assign imem.ftch_imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            BOOT:    state_n = RUN;
            RUN:     state_n = RUN;
            FLUSH:   if (drop_n == '0) state_n = RUN;
            default: state_n = BOOT;
        endcase
        if (exec_ftch_redirect)
            state_n = (outst_n != '0) ? FLUSH : RUN;
    end

    always_comb begin
        imem.ftch_imem_req = 1'b0;
        unique case (state)
            RUN:     imem.ftch_imem_req = credit;
            default: imem.ftch_imem_req = 1'b0;
        endcase
    end

    always_comb begin
        drop_n = drop;
        if (exec_ftch_redirect)
            drop_n = outst_n;
        else if (state == FLUSH && imem.imem_ftch_rvalid)
            drop_n = drop - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else begin
            outst <= outst_n;
            drop  <= drop_n;
            if (exec_ftch_redirect) pc <= tgt;
            else if (fire)          pc <= pc + 32'd4;
        end
    end

    // Request PCs travel beside the bus so responses can be tagged in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orp <= '0;
            owp <= '0;
        end else begin
            if (fire)                  owp <= nxt(owp);
            if (imem.imem_ftch_rvalid) orp <= nxt(orp);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) opc[owp] <= pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftch_dec_instr <= NOP_INSTR;
            ftch_dec_pc    <= RESET_PC;
            ftch_dec_valid <= 1'b0;
        end else if (exec_ftch_redirect) begin
            ftch_dec_instr <= NOP_INSTR;
            ftch_dec_pc    <= tgt;
            ftch_dec_valid <= 1'b0;
        end else if (!dec_ftch_stall) begin
            if (!fempty) begin
                ftch_dec_instr <= head.instr;
                ftch_dec_pc    <= head.pc;
                ftch_dec_valid <= 1'b1;
            end else if (rsp) begin
                ftch_dec_instr <= resp.instr;
                ftch_dec_pc    <= resp.pc;
                ftch_dec_valid <= 1'b1;
            end else begin
                ftch_dec_instr <= NOP_INSTR;
                ftch_dec_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(push && ffull && !pop));
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (exec_ftch_redirect),
        .wdata (resp),
        .rdata (head),
        .count (fcount),
        .full  (ffull),
        .empty (fempty)
    );

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order imem model with programmable latency/grant,
// program-order stream model of the decode outputs, directed scenarios.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [31:0] opc;
    logic        valid;

    fetch_if imem ();

    fetch #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2),
        .MAX_OUTST  (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem               (imem.master),
        .dec_ftch_stall     (stall),
        .exec_ftch_redirect (redir),
        .exec_ftch_target   (tgt),
        .ftch_dec_instr     (instr),
        .ftch_dec_pc        (opc),
        .ftch_dec_valid     (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk  = 0;
    int nfail = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    int          lat    = 1;
    logic        gnt_en = 1'b1;
    logic [31:0] exp_req = RPC;
    logic        rv_seen = 1'b0;

    // Memory: drive at negedge, sample handshakes just before the posedge.
    initial begin
        imem.imem_ftch_gnt    = 1'b0;
        imem.imem_ftch_rvalid = 1'b0;
        imem.imem_ftch_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) q.delete();
            imem.imem_ftch_gnt    = gnt_en;
            imem.imem_ftch_rvalid = (q.size() > 0) && (q[0].due <= cyc);
            imem.imem_ftch_rdata  = imem.imem_ftch_rvalid ?
                                    word(q[0].addr) : 32'h0;
            #4;
            rv_seen = imem.imem_ftch_rvalid && !rst;
            if (!rst) begin
                if (imem.imem_ftch_rvalid) void'(q.pop_front());
                if (imem.ftch_imem_req && imem.imem_ftch_gnt) begin
                    chk("req_addr", imem.ftch_imem_addr, exp_req);
                    exp_req = exp_req + 32'd4;
                    q.push_back('{addr: imem.ftch_imem_addr, due: cyc + lat});
                    chk("outst_le_max", 32'(q.size() > 2), 32'd0);
                end
                if (redir) exp_req = tgt & ~32'h3;
            end else begin
                exp_req = RPC;
            end
        end
    end

    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] exp_pc;
    logic        m_valid;

    function automatic void cmp();
        chk("dec_instr", instr, m_instr);
        chk("dec_pc", opc, m_pc);
        chk("dec_valid", 32'(valid), 32'(m_valid));
    endfunction

    // Decode must see the program in order from the last redirect target.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_instr = NOP_INSTR;
                m_pc    = RPC;
                m_valid = 1'b0;
                exp_pc  = RPC;
            end else if (redir) begin
                m_instr = NOP_INSTR;
                m_pc    = tgt & ~32'h3;
                m_valid = 1'b0;
                exp_pc  = m_pc;
                cmp();
            end else if (stall) begin
                cmp();
            end else if (valid === 1'b1) begin
                m_instr = word(exp_pc);
                m_pc    = exp_pc;
                m_valid = 1'b1;
                exp_pc  = exp_pc + 32'd4;
                cmp();
            end else begin
                m_instr = NOP_INSTR;
                m_valid = 1'b0;
                cmp();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic waitv(input logic [31:0] want, input string nm);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_seen"}, 32'(valid === 1'b1), 32'd1);
        chk(nm, opc, want);
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        tgt   = 32'h0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem.ftch_imem_req), 32'd0);
        chk("rst_addr", imem.ftch_imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", opc, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // boot bubble, then one instruction per cycle
        tick();
        chk("boot_valid", 32'(valid), 32'd0);
        chk("boot_instr", instr, 32'h0000_0013);
        tick();
        chk("first_req_bubble", 32'(valid), 32'd0);
        tick();
        chk("first_pc", opc, 32'h0);
        chk("first_instr", instr, 32'hC0DE_0000);
        chk("first_valid", 32'(valid), 32'd1);
        tick();
        chk("stream_pc4", opc, 32'h4);
        tick();
        chk("stream_pc8", opc, 32'h8);

        // decode stall holds pc 0x8 while the FIFO fills
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", opc, 32'h8);
            chk("stall_instr", instr, 32'hC0DE_0008);
        end
        chk("stall_fifo_full_req", 32'(imem.ftch_imem_req), 32'd0);
        stall = 1'b0;
        tick();
        chk("unstall_pc_c", opc, 32'hC);
        tick();
        chk("unstall_pc_10", opc, 32'h10);

        // two in flight with 2-cycle memory, then redirect
        lat = 2;
        n = 0;
        while (q.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        chk("two_inflight", 32'(q.size()), 32'd2);
        redir = 1'b1;
        tgt   = 32'h103;
        tick();
        redir = 1'b0;
        chk("flush_instr", instr, 32'h0000_0013);
        chk("flush_pc", opc, 32'h100);
        chk("flush_valid", 32'(valid), 32'd0);
        n = 0;
        while (q.size() > 0 && n < 10) begin
            chk("flush_req", 32'(imem.ftch_imem_req), 32'd0);
            tick();
            n++;
        end
        waitv(32'h100, "after_flush_pc");
        chk("after_flush_instr", instr, 32'hC0DE_0100);

        // redirect under stall with a response landing the same cycle
        lat = 1;
        for (int i = 0; i < 3; i++) tick();
        n = 0;
        while (q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        stall = 1'b1;
        redir = 1'b1;
        tgt   = 32'h200;
        tick();
        redir = 1'b0;
        chk("rv_same_cycle", 32'(rv_seen), 32'd1);
        chk("sredir_instr", instr, 32'h0000_0013);
        chk("sredir_pc", opc, 32'h200);
        chk("sredir_valid", 32'(valid), 32'd0);
        stall = 1'b0;
        waitv(32'h200, "after_sredir_pc");

        // 32-bit PC wrap
        redir = 1'b1;
        tgt   = 32'hFFFF_FFFA;
        tick();
        redir = 1'b0;
        waitv(32'hFFFF_FFF8, "wrap_f8");
        tick();
        chk("wrap_fc", opc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_0", opc, 32'h0);
        chk("wrap_0_instr", instr, 32'hC0DE_0000);

        // grant withheld: address parked, bubbles drain out
        gnt_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("nognt_addr", imem.ftch_imem_addr, exp_req);
            if (i >= 4) begin
                chk("nognt_valid", 32'(valid), 32'd0);
                chk("nognt_instr", instr, 32'h0000_0013);
            end
        end
        chk("nognt_req", 32'(imem.ftch_imem_req), 32'd1);
        gnt_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // async reset with a full FIFO
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("prerst_req", 32'(imem.ftch_imem_req), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_instr", instr, 32'h0000_0013);
        chk("arst_pc", opc, 32'h0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_req", 32'(imem.ftch_imem_req), 32'd0);
        chk("arst_addr", imem.ftch_imem_addr, 32'h0);
        tick();
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        waitv(32'h0, "post_rst_pc0");
        tick();
        chk("post_rst_pc4", opc, 32'h4);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
